// File: rtl/gpio_wb_arbiter.sv
// -----------------------------------------------------------------------------
// gpio_wb_arbiter
//
// Two-master Wishbone arbiter in front of a single GPIO slave.
//
// Round-robin selection is applied only when both masters request together.
// A grant is held for the whole bus cycle, for as long as the granted master
// keeps cyc high. At least one IDLE cycle always separates two grants.
//
// A stall watchdog counts the granted master's strobed cycles that receive
// no termination. On the TIMEOUT-th consecutive stalled cycle it does three
// things in that same cycle:
//   - returns a one-cycle err to the granted master,
//   - masks s_stb_o,
//   - restarts the count.
// The grant itself is kept.
//
// Parameters
//   AW       address width of masters and slave
//   TIMEOUT  stalled cycles before a watchdog err (1..255)
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   mN_cyc/stb/we/adr/dat/sel_i  master N request (N = 0, 1)
//   mN_dat_o, mN_ack_o, mN_err_o master N read data and terminations
//   s_cyc/stb/we/adr/dat/sel_o   request forwarded to the GPIO slave
//   s_dat_i, s_ack_i, s_err_i    GPIO slave read data and terminations
//   gnt_o                        one-hot grant {m1, m0}, 00 when idle
// -----------------------------------------------------------------------------
module gpio_wb_arbiter #(
    parameter int AW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [31:0]   m0_dat_i,
    input  logic [3:0]    m0_sel_i,
    output logic [31:0]   m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [31:0]   m1_dat_i,
    input  logic [3:0]    m1_sel_i,
    output logic [31:0]   m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [31:0]   s_dat_o,
    output logic [3:0]    s_sel_o,
    input  logic [31:0]   s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,

    output logic [1:0]    gnt_o
);

    // The encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    // The watchdog fires while the count of previously stalled cycles equals
    // TIMEOUT-1, which makes the current cycle the TIMEOUT-th stalled one.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       rr_q, rr_d;     // master preferred on the next tie
    logic [7:0] cnt_q, cnt_d;   // consecutive stalled cycles

    // Master-side signals gathered into arrays indexed by master number.
    logic [1:0]    m_cyc, m_stb, m_we;
    logic [AW-1:0] m_adr [2];
    logic [31:0]   m_wdat [2];
    logic [3:0]    m_sel [2];

    assign m_cyc     = {m1_cyc_i, m0_cyc_i};
    assign m_stb     = {m1_stb_i, m0_stb_i};
    assign m_we      = {m1_we_i,  m0_we_i};
    assign m_adr[0]  = m0_adr_i;
    assign m_adr[1]  = m1_adr_i;
    assign m_wdat[0] = m0_dat_i;
    assign m_wdat[1] = m1_dat_i;
    assign m_sel[0]  = m0_sel_i;
    assign m_sel[1]  = m1_sel_i;

    logic granted;       // a grant is active
    logic gidx;          // index of the granted master
    logic g_cyc, g_stb;  // granted master's cyc and stb, 0 when idle
    logic stalled;
    logic timeout_hit;
    logic ack_fwd, err_fwd;

    assign granted = (state_q != IDLE);
    assign gidx    = (state_q == GNT1);
    assign g_cyc   = granted & m_cyc[gidx];
    assign g_stb   = granted & m_stb[gidx];

    assign stalled     = g_cyc & g_stb & ~s_ack_i & ~s_err_i;
    assign timeout_hit = stalled & (cnt_q == TO_LAST);

    // Terminations only reach a master that still holds cyc. A dropped cyc
    // aborts the beat. Ack wins over err so the two never coincide.
    assign ack_fwd = g_cyc & s_ack_i;
    assign err_fwd = g_cyc & ~s_ack_i & (s_err_i | timeout_hit);

    // Slave side: combinational copy of the granted master, zero when idle.
    assign s_cyc_o = g_cyc;
    assign s_stb_o = g_stb & ~timeout_hit;
    assign s_we_o  = granted & m_we[gidx];
    assign s_adr_o = granted ? m_adr[gidx]  : '0;
    assign s_dat_o = granted ? m_wdat[gidx] : '0;
    assign s_sel_o = granted ? m_sel[gidx]  : '0;

    assign gnt_o = state_q;

    // Master-side return paths.
    logic [1:0]  m_ack, m_err;
    logic [31:0] m_rdat [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        logic is_gnt;
        assign is_gnt     = granted && (gidx == 1'(gi));
        assign m_ack[gi]  = is_gnt & ack_fwd;
        assign m_err[gi]  = is_gnt & err_fwd;
        assign m_rdat[gi] = is_gnt ? s_dat_i : '0;
    end

    assign m0_ack_o = m_ack[0];
    assign m0_err_o = m_err[0];
    assign m0_dat_o = m_rdat[0];
    assign m1_ack_o = m_ack[1];
    assign m1_err_o = m_err[1];
    assign m1_dat_o = m_rdat[1];

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                // The pointer always moves to the master not being granted.
                if (m_cyc == 2'b11) begin
                    state_d = rr_q ? GNT1 : GNT0;
                    rr_d    = ~rr_q;
                end else if (m_cyc[0]) begin
                    state_d = GNT0;
                    rr_d    = 1'b1;
                end else if (m_cyc[1]) begin
                    state_d = GNT1;
                    rr_d    = 1'b0;
                end
            end
            GNT0, GNT1: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog: clear on idle, on a grant change, on any termination
        // and on its own expiry. Count up only on stalled cycles, so stb
        // gaps hold the count.
        if (!granted || (state_d != state_q) || (g_cyc && (s_ack_i || s_err_i)) || timeout_hit) begin
            cnt_d = '0;
        end else if (stalled) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpio_wb_arbiter
//
// Directed bench for gpio_wb_arbiter. It acts as both masters and as the
// slave. Inputs change 1 ns after a rising edge. Outputs are checked 1 ns
// after each input change, well before the next edge.
// -----------------------------------------------------------------------------
module tb_gpio_wb_arbiter;

    localparam int AW = 4;

    logic          wb_clk_i;
    logic          wb_rst_ni;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [31:0]   m0_dat_i;
    logic [3:0]    m0_sel_i;
    logic [31:0]   m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [31:0]   m1_dat_i;
    logic [3:0]    m1_sel_i;
    logic [31:0]   m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [31:0]   s_dat_o;
    logic [3:0]    s_sel_o;
    logic [31:0]   s_dat_i;
    logic          s_ack_i, s_err_i;
    logic [1:0]    gnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_wb_arbiter #(.AW(AW), .TIMEOUT(15)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_sel_i (m0_sel_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_sel_i (m1_sel_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .gnt_o    (gnt_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic set_m0(input logic cyc, input logic stb);
        m0_cyc_i = cyc;
        m0_stb_i = stb;
    endtask

    task automatic set_m1(input logic cyc, input logic stb);
        m1_cyc_i = cyc;
        m1_stb_i = stb;
    endtask

    task automatic do_reset();
        wb_rst_ni = 1'b0;
        step();
        step();
        wb_rst_ni = 1'b1;
    endtask

    initial begin
        wb_rst_ni = 1'b0;
        set_m0(1'b0, 1'b0);
        set_m1(1'b0, 1'b0);
        m0_we_i = 1'b0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_we_i = 1'b0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;

        // Reset state, with a slave ack present to prove the outputs are gated.
        step();
        s_ack_i = 1'b1;
        #1;
        check_val("rst_gnt",    32'(gnt_o),    32'h0);
        check_val("rst_s_cyc",  32'(s_cyc_o),  32'h0);
        check_val("rst_s_stb",  32'(s_stb_o),  32'h0);
        check_val("rst_m0_ack", 32'(m0_ack_o), 32'h0);
        s_ack_i = 1'b0;
        step();
        wb_rst_ni = 1'b1;

        // m0 single write.
        set_m0(1'b1, 1'b1);
        m0_we_i = 1'b1; m0_adr_i = 4'h4; m0_dat_i = 32'h00A5A5A5; m0_sel_i = 4'hF;
        #1;
        check_val("w_gnt_pre", 32'(gnt_o), 32'h0);
        step();
        check_val("w_gnt",   32'(gnt_o),   32'h1);
        check_val("w_s_cyc", 32'(s_cyc_o), 32'h1);
        check_val("w_s_stb", 32'(s_stb_o), 32'h1);
        check_val("w_s_we",  32'(s_we_o),  32'h1);
        check_val("w_s_adr", 32'(s_adr_o), 32'h4);
        check_val("w_s_dat", s_dat_o,      32'h00A5A5A5);
        check_val("w_s_sel", 32'(s_sel_o), 32'hF);
        s_ack_i = 1'b1;
        #1;
        check_val("w_m0_ack", 32'(m0_ack_o), 32'h1);
        check_val("w_m0_err", 32'(m0_err_o), 32'h0);
        check_val("w_m1_ack", 32'(m1_ack_o), 32'h0);
        step();
        set_m0(1'b0, 1'b0);
        m0_we_i = 1'b0;
        s_ack_i = 1'b0;
        step();
        check_val("w_gnt_end", 32'(gnt_o), 32'h0);

        // Tie after reset: m0 first, one IDLE cycle, then m1, next tie to m0.
        do_reset();
        set_m0(1'b1, 1'b1);
        set_m1(1'b1, 1'b1);
        m1_adr_i = 4'h8;
        step();
        check_val("tie_gnt0", 32'(gnt_o), 32'h1);
        s_dat_i = 32'h12345678;
        s_ack_i = 1'b1;
        #1;
        check_val("tie_m0_dat", m0_dat_o,        32'h12345678);
        check_val("tie_m1_dat", m1_dat_o,        32'h0);
        check_val("tie_m0_ack", 32'(m0_ack_o),   32'h1);
        check_val("tie_m1_ack", 32'(m1_ack_o),   32'h0);
        step();
        set_m0(1'b0, 1'b0);
        s_ack_i = 1'b0;
        #1;
        check_val("tie_drop_s_cyc", 32'(s_cyc_o), 32'h0);
        step();
        check_val("tie_idle_gnt", 32'(gnt_o), 32'h0);
        step();
        check_val("tie_gnt1",  32'(gnt_o),   32'h2);
        check_val("tie_s_adr", 32'(s_adr_o), 32'h8);
        s_ack_i = 1'b1;
        #1;
        check_val("tie_m1_ack2", 32'(m1_ack_o), 32'h1);
        check_val("tie_m0_ack2", 32'(m0_ack_o), 32'h0);
        check_val("tie_m1_dat2", m1_dat_o,      32'h12345678);
        check_val("tie_m0_dat2", m0_dat_o,      32'h0);
        step();
        set_m1(1'b0, 1'b0);
        s_ack_i = 1'b0;
        step();
        check_val("tie_idle2", 32'(gnt_o), 32'h0);
        set_m0(1'b1, 1'b1);
        set_m1(1'b1, 1'b1);
        step();
        check_val("tie_next_m0", 32'(gnt_o), 32'h1);
        set_m0(1'b0, 1'b0);
        set_m1(1'b0, 1'b0);
        step();

        // m1 holds cyc for 3 beats while m0 waits. The tie goes to m1 because
        // m0 was granted last.
        set_m0(1'b1, 1'b1);
        set_m1(1'b1, 1'b1);
        step();
        for (int b = 0; b < 3; b++) begin
            s_ack_i = 1'b1;
            #1;
            check_val($sformatf("mb_gnt_%0d", b),    32'(gnt_o),    32'h2);
            check_val($sformatf("mb_m1_ack_%0d", b), 32'(m1_ack_o), 32'h1);
            check_val($sformatf("mb_m0_ack_%0d", b), 32'(m0_ack_o), 32'h0);
            step();
            s_ack_i = 1'b0;
        end
        set_m1(1'b0, 1'b0);
        step();
        check_val("mb_idle", 32'(gnt_o), 32'h0);
        step();
        check_val("mb_gnt0", 32'(gnt_o), 32'h1);
        set_m0(1'b0, 1'b0);
        step();

        // Slave never responds: err on the 15th stalled cycle, grant kept.
        set_m0(1'b1, 1'b1);
        step();
        for (int k = 1; k <= 15; k++) begin
            #1;
            check_val($sformatf("to_err_%0d", k), 32'(m0_err_o), 32'(k == 15));
            check_val($sformatf("to_stb_%0d", k), 32'(s_stb_o),  32'(k != 15));
            check_val($sformatf("to_gnt_%0d", k), 32'(gnt_o),    32'h1);
            step();
        end
        check_val("to_after_err", 32'(m0_err_o), 32'h0);
        check_val("to_after_stb", 32'(s_stb_o),  32'h1);
        set_m0(1'b0, 1'b0);
        step();

        // Slave ack on the cycle the watchdog would fire: ack passes, no err.
        set_m0(1'b1, 1'b1);
        step();
        for (int k = 1; k < 15; k++) begin
            step();
        end
        s_ack_i = 1'b1;
        #1;
        check_val("race_ack", 32'(m0_ack_o), 32'h1);
        check_val("race_err", 32'(m0_err_o), 32'h0);
        check_val("race_stb", 32'(s_stb_o),  32'h1);
        step();
        s_ack_i = 1'b0;
        #1;
        check_val("race_next_err", 32'(m0_err_o), 32'h0);
        set_m0(1'b0, 1'b0);
        step();

        // Reset between edges during GNT1.
        set_m1(1'b1, 1'b1);
        step();
        check_val("ar_gnt1",  32'(gnt_o),   32'h2);
        check_val("ar_s_cyc", 32'(s_cyc_o), 32'h1);
        s_ack_i = 1'b1;
        set_m0(1'b1, 1'b1);
        #1;
        wb_rst_ni = 1'b0;
        #1;
        check_val("ar_s_cyc_rst",  32'(s_cyc_o),  32'h0);
        check_val("ar_s_stb_rst",  32'(s_stb_o),  32'h0);
        check_val("ar_gnt_rst",    32'(gnt_o),    32'h0);
        check_val("ar_m1_ack_rst", 32'(m1_ack_o), 32'h0);
        step();
        step();
        wb_rst_ni = 1'b1;
        s_ack_i = 1'b0;
        #1;
        check_val("ar_gnt_rel", 32'(gnt_o), 32'h0);
        step();
        check_val("ar_tie_m0", 32'(gnt_o), 32'h1);
        set_m0(1'b0, 1'b0);
        set_m1(1'b0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
